bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter: WIDTH, 20, data word width and multiplexor input count.
REQ-002 Parameter: ADDR_W, 5, bit-select address width.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: in_data  input  WIDTH  parallel word to serialize.
REQ-006 Port: in_len  input  ADDR_W  number of bits to send; sampled with in_data.
REQ-007 Port: in_valid  input  1  upstream word available.
REQ-008 Port: in_ready  output  1  block can accept a word.
REQ-009 Port: out_bit  output  1  current serial bit, LSB first.
REQ-010 Port: out_valid  output  1  out_bit is valid.
REQ-011 Port: out_ready  input  1  downstream accepts out_bit.
REQ-012 Port: out_last  output  1  current bit is the final bit of the word.
REQ-013 Port: busy  output  1  a word is being serialized.

Function
REQ-014 The block SHALL have two states, IDLE and SEND.
REQ-015 In IDLE, in_ready SHALL be 1, and out_valid, out_last and busy SHALL be 0.
REQ-016 In SEND, in_ready SHALL be 0, and out_valid and busy SHALL be 1.
REQ-017 On an input handshake (in_valid && in_ready), the block SHALL register in_data and the effective length, clear the bit address to 0, and enter SEND on the next cycle.
REQ-018 The effective length SHALL be 20 when in_len is 0 or greater than 20; otherwise it SHALL equal in_len.
REQ-019 out_bit SHALL equal the registered word bit indexed by the bit address.
REQ-020 The bit selection SHALL be made through the multiplexor sub-module, with in = registered word, addr = bit address, and out = out_bit.
REQ-021 In IDLE, out_bit SHALL be 0.
REQ-022 out_last SHALL be 1 in SEND exactly when the bit address equals effective length - 1.
REQ-023 On an output handshake (out_valid && out_ready) where out_last is 0, the bit address SHALL increment by 1.
REQ-024 On an output handshake where out_last is 1, the block SHALL return to IDLE.
REQ-025 While out_valid is 1 and out_ready is 0, out_bit, out_last and the bit address SHALL hold stable.
REQ-026 The bit address SHALL never exceed 19; no wrap-around occurs within a word.
REQ-027 Input acceptance latency SHALL be 1 cycle: the first bit is valid in the cycle after the input handshake.
REQ-028 The block SHALL insert one IDLE cycle between consecutive words; in_ready is not asserted in the cycle of the last output handshake.
REQ-029 in_ready and out_valid SHALL depend only on state, with no combinational path from in_valid or out_ready.

Reset
REQ-030 While rst_n is 0, regardless of clk, the block SHALL force state to IDLE, bit address to 0 and the registered word to 0.
REQ-031 Reset values SHALL be: in_ready 1, out_valid 0, out_bit 0, out_last 0, busy 0.
REQ-032 A reset asserted mid-word SHALL abandon the word without emitting further bits.
REQ-033 After reset release, the next accepted word SHALL start at bit 0.

Structure
REQ-034 A shared package SHALL hold WIDTH (20), ADDR_W (5) and the IDLE/SEND state encoding.
REQ-035 The block SHALL instantiate exactly one existing multiplexor sub-module; no other sub-modules are needed.

Verification
REQ-036 Reset: hold rst_n=0 with clk stopped -> in_ready=1, out_valid=0, out_bit=0, out_last=0, busy=0.
REQ-037 Full word: in_data=20'h00001, in_len=0, out_ready=1 -> 20 beats, beat 1 out_bit=1, beats 2-20 out_bit=0, out_last on beat 20 only, in_ready=1 the following cycle.
REQ-038 Short word: in_data=20'h0000A, in_len=4 -> beats 0,1,0,1 with out_last on beat 4, then one IDLE cycle.
REQ-039 Backpressure: in_data=20'hFFFF0, in_len=8, out_ready=0 for 3 cycles at beat 5 -> out_bit=1 and out_last=0 held stable for those 3 cycles, sequence 0,0,0,0,1,1,1,1 unchanged.
REQ-040 Clamp: in_len=25, in_data=20'h80000 -> 20 beats, only beat 20 out_bit=1, with out_last=1 on beat 20.
REQ-041 Mid-word reset: assert rst_n=0 after 5 beats of a 20-bit word -> out_valid falls immediately (no clock edge needed); after release, a new word 20'h00003 with in_len=2 emits 1,1.

Source files
------------

// File: rtl/bit_serializer_pkg.sv
// Shared constants for the bit serializer: word width, bit-address width, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package bit_serializer_pkg;

    // Parallel word width, which is also the number of mux inputs.
    localparam int SER_WIDTH  = 20;
    // Bit-address width, wide enough to index every bit of the word.
    localparam int SER_ADDR_W = 5;

    // FSM encoding. Kept as plain logic constants so older tools can read it.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

endpackage

// File: rtl/bit_serializer_mux.sv
// WIDTH:1 bit-select multiplexor. An address outside the word selects 0.
// Latency: combinational, 0 cycles.
// Backpressure: none. The output follows the inputs.
module bit_serializer_mux #(
    parameter int WIDTH  = 20,
    parameter int ADDR_W = 5
) (
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] addr,
    output logic              out
);

    // Compare against each index so that no out-of-range part-select is ever formed.
    always_comb begin
        out = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (addr == ADDR_W'(i)) begin
                out = in[i];
            end
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Serializes one parallel word, LSB first, over a valid/ready bit stream.
// Latency: the first bit is valid 1 cycle after input acceptance, with 1 IDLE cycle between words.
// Backpressure: out_ready low freezes the bit, last flag and address. in_ready depends only on state.
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH  = SER_WIDTH,
    parameter int ADDR_W = SER_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [ADDR_W-1:0] in_len,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy
);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] last_q,  last_d;
    logic [WIDTH-1:0]  word_q,  word_d;
    logic [ADDR_W-1:0] in_last_idx;

    // Index of the final bit. A length of 0, or one longer than the word, means the full word.
    always_comb begin
        if ((in_len == '0) || (in_len > ADDR_W'(WIDTH))) begin
            in_last_idx = ADDR_W'(WIDTH - 1);
        end else begin
            in_last_idx = in_len - ADDR_W'(1);
        end
    end

    // Handshake outputs come only from state, so there is no path from in_valid or out_ready.
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_SEND);
    assign busy      = (state_q == ST_SEND);
    assign out_last  = out_valid && (addr_q == last_q);

    // Next-state logic. The word register is cleared when a word finishes, so out_bit reads 0 in IDLE.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        last_d  = last_q;
        word_d  = word_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_SEND;
                    word_d  = in_data;
                    addr_d  = '0;
                    last_d  = in_last_idx;
                end
            end
            default: begin
                if (out_ready) begin
                    if (out_last) begin
                        state_d = ST_IDLE;
                        word_d  = '0;
                        addr_d  = '0;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                end
            end
        endcase
    end

    // State registers. Reset abandons any word in flight at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            last_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            word_q  <= word_d;
        end
    end

    // Bit selection goes through the shared multiplexor.
    bit_serializer_mux #(
        .WIDTH  (WIDTH),
        .ADDR_W (ADDR_W)
    ) u_mux (
        .in   (word_q),
        .addr (addr_q),
        .out  (out_bit)
    );

endmodule

// File: tb/tb_bit_serializer.sv
module tb_bit_serializer;

    logic        clk = 1'b0;
    bit          clk_en = 1'b0;
    logic        rst_n;
    logic [19:0] in_data;
    logic [4:0]  in_len;
    logic        in_valid;
    logic        in_ready;
    logic        out_bit;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
    logic        busy;

    int errors = 0;
    int checks = 0;

    always #5 if (clk_en) clk = ~clk;

    bit_serializer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_len    (in_len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .busy      (busy)
    );

    // Send one word and check every beat against the reference bit list.
    // Vector order: {out_valid, in_ready, out_last, out_bit, busy}.
    task automatic send_word(input logic [19:0] d, input logic [4:0] len,
                             input int stall_at, input int stall_n, input string name);
        int          n;
        int          guard;
        logic        exp_bits[$];
        logic [4:0]  got;
        logic [4:0]  exp;
        n = (len == 0 || len > 20) ? 20 : int'(len);
        exp_bits.delete();
        for (int i = 0; i < n; i++) exp_bits.push_back(((d >> i) & 20'd1) != 0);

        guard = 0;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: in_ready=%b required 1", name, in_ready);
        end

        in_data  = d;
        in_len   = len;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_data  = 20'($urandom);
        in_len   = 5'($urandom);

        for (int k = 0; k < n; k++) begin
            exp = {1'b1, 1'b0, (k == n - 1), exp_bits[k], 1'b1};
            got = {out_valid, in_ready, out_last, out_bit, busy};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL %s beat%0d: got %b required %b", name, k + 1, got, exp);
            end
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    got = {out_valid, in_ready, out_last, out_bit, busy};
                    checks++;
                    if (got !== exp) begin
                        errors++;
                        $display("FAIL %s stall%0d_beat%0d: got %b required %b", name, s, k + 1, got, exp);
                    end
                end
                out_ready = 1'b1;
            end
            @(posedge clk); #1;
        end

        got = {out_valid, in_ready, out_last, out_bit, busy};
        checks++;
        if (got !== 5'b01000) begin
            errors++;
            $display("FAIL %s idle_after: got %b required 01000", name, got);
        end
    endtask

    task automatic test_reset();
        logic [4:0] got;
        clk_en    = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_len    = '0;
        out_ready = 1'b1;
        #3;
        got = {out_valid, in_ready, out_last, out_bit, busy};
        checks++;
        if (got !== 5'b01000) begin
            errors++;
            $display("FAIL reset_state: got %b required 01000", got);
        end
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_word();
        send_word(20'h00001, 5'd0, -1, 0, "full_word");
    endtask

    task automatic test_short_word();
        send_word(20'h0000A, 5'd4, -1, 0, "short_word");
    endtask

    task automatic test_backpressure();
        send_word(20'hFFFF0, 5'd8, 4, 3, "backpressure");
    endtask

    task automatic test_clamp();
        send_word(20'h80000, 5'd25, -1, 0, "clamp");
    endtask

    task automatic test_midword_reset();
        logic [4:0] got;
        in_data  = 20'hABCDE;
        in_len   = 5'd0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre: out_valid=%b required 1", out_valid);
        end
        rst_n = 1'b0;
        #1;
        got = {out_valid, in_ready, out_last, out_bit, busy};
        checks++;
        if (got !== 5'b01000) begin
            errors++;
            $display("FAIL midreset_async: got %b required 01000", got);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_word(20'h00003, 5'd2, -1, 0, "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            send_word(20'($urandom), 5'($urandom_range(0, 31)),
                      int'($urandom_range(0, 24)), int'($urandom_range(0, 3)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_word();
        test_backpressure();
        test_clamp();
        test_midword_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
